// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory port.
//   size encodings : SZ_B / SZ_H / SZ_W / SZ_D  (1, 2, 4, 8 bytes)
//   error codes    : ERR_OK / ERR_MISALIGN / ERR_TIMEOUT / ERR_SIZE
//   FSM states     : lsu_state_e
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Access width in bytes for a size encoding.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment and load extension for one XLEN-wide memory beat.
// Purely combinational.
//   off          in   byte offset of the access inside the beat
//   size         in   access size encoding (SZ_B..SZ_D)
//   req_unsigned in   1 = zero-extend load data, 0 = sign-extend
//   wdata        in   LSB-aligned store data
//   rdata        in   raw read beat from memory
//   wmask        out  byte strobes for the access
//   wdata_sh     out  store data moved onto its byte lanes
//   rdata_ext    out  load data moved down to bit 0 and extended to XLEN
//   misalign     out  address not a multiple of the access size
//   illegal      out  access size wider than the datapath
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size,
    input  logic                      req_unsigned,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN/8-1:0]         wmask,
    output logic [XLEN-1:0]           wdata_sh,
    output logic [XLEN-1:0]           rdata_ext,
    output logic                      misalign,
    output logic                      illegal
);

    localparam int NB = XLEN / 8;

    logic [3:0]      nbytes;
    logic [XLEN-1:0] rdata_sh;
    logic            sign;
    int              nbits;

    always_comb begin
        nbytes   = size_bytes(size);
        illegal  = (XLEN == 32) && (size == SZ_D);
        misalign = |(4'(off) & (nbytes - 4'd1));

        for (int i = 0; i < NB; i++) begin
            wmask[i] = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
        end

        wdata_sh = wdata << {off, 3'b000};
        rdata_sh = rdata >> {off, 3'b000};

        // A full-width access (dword on 64-bit, word on 32-bit) passes the
        // beat through untouched, so the kept width is capped at XLEN.
        nbits = (int'(nbytes) * 8 > XLEN) ? XLEN : int'(nbytes) * 8;

        case (size)
            SZ_B:    sign = rdata_sh[7];
            SZ_H:    sign = rdata_sh[15];
            SZ_W:    sign = rdata_sh[31];
            default: sign = rdata_sh[XLEN-1];
        endcase
        sign = sign & ~req_unsigned;

        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = (i < nbits) ? rdata_sh[i] : sign;
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Multi-cycle load/store unit: takes one request at a time from execute,
// issues a single beat on a valid/ready memory port and returns extended
// load data or a store acknowledge together with an error code.
//   clk, rst             clock, asynchronous active-high reset
//   req_*                request from execute (valid/ready)
//   resp_*               response to writeback (valid/ready)
//   mem_req_* / mem_*    beat request to memory (valid/ready, registered)
//   mem_rsp_valid/rdata  read data or write acknowledge from memory
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; alignment/size errors skip to RESP
// REQ     | mem_req_valid high, mem_* held until mem_req_ready
// WAIT    | waiting for mem_rsp_valid, timeout timer running
// RESP    | resp_valid high, resp_* held until resp_ready
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [4:0]          resp_rd,
    output logic [1:0]          resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The timer counts down from TIMEOUT-1; reaching zero in WAIT means
    // TIMEOUT cycles have been spent waiting.
    localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_e state, state_nxt;

    logic             wen_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [OFF_W-1:0] off_q;
    logic [CNT_W-1:0] cnt_q;

    logic             idle;
    logic             tmo_hit;
    logic [OFF_W-1:0] al_off;
    logic [1:0]       al_size;
    logic             al_uns;
    logic [NB-1:0]    al_wmask;
    logic [XLEN-1:0]  al_wdata;
    logic [XLEN-1:0]  al_rdata;
    logic             al_misalign;
    logic             al_illegal;

    assign idle    = (state == ST_IDLE);
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == '0);

    // In IDLE the aligner looks at the incoming request; afterwards it
    // works from the latched request so load extension in WAIT is correct.
    assign al_off  = idle ? req_addr[OFF_W-1:0] : off_q;
    assign al_size = idle ? req_size            : size_q;
    assign al_uns  = idle ? req_unsigned        : uns_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .off          (al_off),
        .size         (al_size),
        .req_unsigned (al_uns),
        .wdata        (req_wdata),
        .rdata        (mem_rdata),
        .wmask        (al_wmask),
        .wdata_sh     (al_wdata),
        .rdata_ext    (al_rdata),
        .misalign     (al_misalign),
        .illegal      (al_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (al_illegal || al_misalign) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid || tmo_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q      <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            off_q      <= '0;
            cnt_q      <= '0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_err   <= ERR_OK;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q      <= req_wen;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        off_q      <= req_addr[OFF_W-1:0];
                        resp_rd    <= req_rd;
                        resp_rdata <= '0;
                        if (al_illegal) begin
                            resp_err <= ERR_SIZE;
                        end else if (al_misalign) begin
                            resp_err <= ERR_MISALIGN;
                        end else begin
                            resp_err  <= ERR_OK;
                            mem_wen   <= req_wen;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= al_wdata;
                            mem_wmask <= al_wmask;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        cnt_q <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    // A response in the same cycle the timer expires still wins.
                    if (mem_rsp_valid) begin
                        resp_err   <= ERR_OK;
                        resp_rdata <= wen_q ? '0 : al_rdata;
                    end else if (tmo_hit) begin
                        resp_err   <= ERR_TIMEOUT;
                        resp_rdata <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised, multi-cycle load/store unit that replaces the stubbed single-cycle memory path of the core.
- Accepts one load/store request at a time from execute and drives an XLEN-wide valid/ready memory port with byte masks.
- Returns sign- or zero-extended load data, or a store acknowledge, with an error code.
- Sits between the core datapath and the DPI-backed physical memory adapter.

Parameters:
- XLEN, 64, datapath width; legal values are 32 or 64. Memory beat is XLEN bits.
- ADDR_W, 64, address width.
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  LSU can accept a request
- req_wen  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_unsigned  in  1  zero-extend load data (lbu/lhu/lwu)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- req_rd  in  5  destination register tag
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_rd  out  5  echoed tag
- resp_err  out  2  0=ok, 1=misaligned, 2=timeout, 3=illegal size
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_wen  out  1  write enable
- mem_addr  out  ADDR_W  beat-aligned address: low OFF_W bits are 0, where OFF_W = log2(XLEN/8)
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  XLEN/8  byte strobes
- mem_rsp_valid  in  1  read data or write acknowledge
- mem_rdata  in  XLEN  read beat

Behaviour:
- Reset state:
  - State is IDLE and every register is cleared.
  - req_ready=1; resp_valid=0; mem_req_valid=0; resp_err=0; resp_rdata=0; mem_wmask=0.
  - An asserted rst mid-transaction aborts the transaction immediately; no response is ever produced for it.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_ready=1.
    - On req_valid, latch all req_* fields.
    - If the size is illegal (size 3 when XLEN=32), go to RESP with err=3.
    - Else if addr[log2(bytes)-1:0]!=0, go to RESP with err=1. No memory access occurs in either error case.
    - Otherwise go to REQ.
  - REQ: mem_req_valid=1. All mem_* outputs are registered and stay stable until mem_req_ready. On the handshake, go to WAIT and clear the timeout counter.
  - WAIT: mem_req_valid=0.
    - mem_rsp_valid is sampled only in WAIT.
    - On mem_rsp_valid, capture the extended data (loads) and go to RESP with err=0.
    - Otherwise the counter increments. When TIMEOUT!=0 and counter==TIMEOUT-1, go to RESP with err=2.
  - RESP: resp_valid=1, held with all resp_* fields stable until resp_ready; then go to IDLE. req_ready=0 in every non-IDLE state.
- Ordering and latency:
  - Each transaction is strictly serial; there is never more than one outstanding memory request.
  - mem_rsp_valid arriving in IDLE, REQ or RESP (for example a stale beat after a timeout) is ignored.
  - Minimum latency from req handshake to resp_valid is 3 cycles, assuming mem_req_ready=1 and mem_rsp_valid is high one cycle after the handshake.
  - Misaligned or illegal-size requests respond with resp_valid high 1 cycle after acceptance.
- Lane and extension arithmetic (off = addr[OFF_W-1:0], bytes = 1<<size):
  - mem_wmask = ((1<<bytes)-1) << off.
  - mem_wdata = req_wdata << (8*off).
  - For loads: mem_wen=0 and mem_wmask equals the read mask (informational).
  - Load data: shift mem_rdata right by 8*off, truncate to 8*bytes bits, then sign-extend (req_unsigned=0) or zero-extend to XLEN.
  - A dword (size 3) with XLEN=64 returns the beat unchanged.
  - Stores: resp_rdata=0.

Decomposition:
- Package lsu_pkg holds:
  - the size encodings (SZ_B, SZ_H, SZ_W, SZ_D),
  - the error codes (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_SIZE),
  - the FSM state enum.
- One combinational sub-module, lsu_align(XLEN), computes wmask, the shifted wdata, the misalign/illegal flags and the extended rdata. lsu_mem_port holds the FSM, the request/response registers and the timeout counter.

Test Plan:
- Store: XLEN=64, sw addr=0x80000004, wdata=0x11223344 -> mem_addr=0x80000000, wmask=0xF0, wdata=0x11223344_00000000; resp_err=0, resp_rdata=0.
- Signed byte load: lb addr=0x80000003, mem_rdata=0x00000000_80FF0000 -> resp_rdata=0xFFFFFFFF_FFFFFF80. Same beat with lbu -> 0x80.
- Halfword load: lh addr=0x80000002, mem_rdata=0x...._80FF_0000 -> resp_rdata=0xFFFFFFFF_FFFF80FF. lwu addr=0x80000004, mem_rdata=0xDEADBEEF_00000000 -> 0x00000000_DEADBEEF.
- Misaligned: lw addr=0x80000002 -> mem_req_valid never asserts; resp_valid 1 cycle later with err=1, rd echoed.
- Back-pressure and timeout: TIMEOUT=4, mem_req_ready held low 3 cycles -> mem_* outputs stable throughout; then no mem_rsp_valid -> err=2 after 4 WAIT cycles. A late mem_rsp_valid in IDLE is ignored and the next request completes correctly. resp_ready low 5 cycles -> resp fields stay stable.
- Reset and XLEN=32: asserting rst in WAIT clears all outputs the same cycle and the next request works normally. With XLEN=32, size=3 -> err=3.
